fma_dot_sequencer: RTL and testbench
====================================

// Module: fma_dot_sequencer
// PURPOSE
//  Sequences one shared BF16xBF16+FP32 fused multiply-add unit through a dot product of LEN operand pairs.
//  Accepts streamed BF16 A/B pairs and feeds each pair to the FMA with the running FP32 accumulator as C.
//  Writes each FMA result back into the accumulator, then reports the final sum.
//  Sits between the operand-fetch logic and the FMA datapath (unpack -> multiply -> align -> add -> round).
// PARAMETERS
//  WIDTH      16   operand A/B width (BF16)
//  CWIDTH     32   accumulator/C width (FP32)
//  LEN_W      8    width of vector-length field; max LEN = 2^LEN_W-1
//  TO_W       6    width of FMA-result timeout counter
//  TIMEOUT    40   cycles in WAIT without fma_res_valid before error abort
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  start         in   1       1-cycle pulse: begin dot product (ignored unless IDLE)
//  abort         in   1       synchronous abort, any state -> IDLE
//  len           in   LEN_W   number of A/B pairs, sampled on start
//  init_c        in   CWIDTH  initial accumulator value, sampled on start
//  op_valid      in   1       A/B pair available
//  op_ready      out  1       sequencer accepts pair this cycle
//  op_a          in   WIDTH   BF16 multiplicand
//  op_b          in   WIDTH   BF16 multiplier
//  fma_req       out  1       1-cycle issue strobe to FMA
//  fma_a         out  WIDTH   registered A to FMA
//  fma_b         out  WIDTH   registered B to FMA
//  fma_c         out  CWIDTH  registered accumulator to FMA
//  fma_res_valid in   1       FMA result strobe (any latency >=1)
//  fma_res       in   CWIDTH  FMA FP32 result
//  busy          out  1       high in FETCH/ISSUE/WAIT
//  done          out  1       1-cycle pulse: acc_out valid
//  acc_out       out  CWIDTH  final sum, held until next start
//  err           out  1       sticky timeout flag, cleared on next accepted start
// BEHAVIOUR
//  Reset: state=IDLE. Outputs op_ready, fma_req, busy, done and err are 0.
//   acc_out, fma_a, fma_b, fma_c and all counters reset to 0.
//  IDLE: start & len!=0 -> acc<=init_c, cnt<=0, err<=0, go FETCH.
//   start & len==0 -> acc_out<=init_c, done=1 next cycle, stay IDLE.
//  FETCH: op_ready=1.
//   On op_valid&op_ready: latch op_a/op_b into fma_a/fma_b and acc into fma_c, go ISSUE.
//  ISSUE: fma_req=1 for exactly this cycle; timer<=0; go WAIT.
//  WAIT: op_ready=0; timer increments each cycle.
//   fma_res_valid -> acc<=fma_res, cnt<=cnt+1.
//    If cnt+1==len_q, go DONE; otherwise go FETCH.
//   timer==TIMEOUT-1 with no fma_res_valid -> err<=1, go DONE.
//   fma_res_valid and the timeout in the same cycle: the result wins, no error.
//  DONE: acc_out<=acc, done=1 for one cycle, go IDLE.
//  Minimum per-pair cost: 1 FETCH + 1 ISSUE + FMA latency.
//   Only one FMA op is outstanding at any time (true accumulate dependency).
//  fma_res_valid outside WAIT is ignored, and acc is unchanged.
//  start while busy: ignored; len_q and init_c are not resampled.
//  abort has priority over every transition: go IDLE, no done, acc_out unchanged, err unchanged.
//   An FMA result in flight after abort is ignored.
//  rst_n low mid-operation: immediate return to reset values. No done pulse.
//  No arithmetic in this block; FP special values pass through the FMA untouched.
// TESTING
//  Model FMA latency 3. len=2, init_c=0x3F800000, pairs (0x3F80,0x4000),(0x4000,0x4000)
//   -> two fma_req pulses, fma_c 0x3F800000 then 0x40400000.
//   -> done with acc_out=0x40E00000 (7.0), err=0.
//  start with len=0, init_c=0x40400000 -> done next cycle, acc_out=0x40400000, no fma_req.
//  op_valid deasserted for 5 cycles mid-vector -> stays FETCH, no fma_req.
//   Result is identical to the no-stall run.
//  Model FMA never returns -> err=1 and done after TIMEOUT cycles in WAIT, acc_out=pre-op acc.
//   Next start clears err.
//  abort asserted in WAIT, late fma_res_valid 2 cycles later -> IDLE, no done, acc_out unchanged.
//  start pulsed while busy and rst_n pulsed mid-WAIT -> start ignored.
//   After reset all outputs are 0; a fresh start completes normally.

Source files
------------

// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer for one shared BF16xBF16+FP32 FMA unit.
// Streams A/B pairs, keeps one FMA op in flight, accumulates in FP32.
module fma_dot_sequencer #(
   parameter int WIDTH   = 16,
   parameter int CWIDTH  = 32,
   parameter int LEN_W   = 8,
   parameter int TO_W    = 6,
   parameter int TIMEOUT = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  len,
   input  logic [CWIDTH-1:0] init_c,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   output logic              fma_req,
   output logic [WIDTH-1:0]  fma_a,
   output logic [WIDTH-1:0]  fma_b,
   output logic [CWIDTH-1:0] fma_c,
   input  logic              fma_res_valid,
   input  logic [CWIDTH-1:0] fma_res,
   output logic              busy,
   output logic              done,
   output logic [CWIDTH-1:0] acc_out,
   output logic              err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic [CWIDTH-1:0] acc_q, acc_d;
   logic [CWIDTH-1:0] acc_out_q, acc_out_d;
   logic [WIDTH-1:0]  fma_a_q, fma_a_d;
   logic [WIDTH-1:0]  fma_b_q, fma_b_d;
   logic [CWIDTH-1:0] fma_c_q, fma_c_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [LEN_W-1:0]  cnt_inc;

   assign cnt_inc  = cnt_q + LEN_W'(1);
   assign op_ready = (state_q == S_FETCH) & ~abort;
   assign fma_req  = (state_q == S_ISSUE) & ~abort;
   assign busy     = (state_q == S_FETCH) | (state_q == S_ISSUE) |
                     (state_q == S_WAIT);
   assign fma_a    = fma_a_q;
   assign fma_b    = fma_b_q;
   assign fma_c    = fma_c_q;
   assign done     = done_q;
   assign acc_out  = acc_out_q;
   assign err      = err_q;

   // Next-state logic; abort overrides everything and holds all state.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      acc_d     = acc_q;
      acc_out_d = acc_out_q;
      fma_a_d   = fma_a_q;
      fma_b_d   = fma_b_q;
      fma_c_d   = fma_c_q;
      done_d    = 1'b0;
      err_d     = err_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     len_d   = len;
                     acc_d   = init_c;
                     cnt_d   = '0;
                     err_d   = 1'b0;
                     state_d = S_FETCH;
                  end else begin
                     acc_out_d = init_c;
                     done_d    = 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (op_valid) begin
                  fma_a_d = op_a;
                  fma_b_d = op_b;
                  fma_c_d = acc_q;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer_d = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               timer_d = timer_q + TO_W'(1);
               if (fma_res_valid) begin
                  acc_d   = fma_res;
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == len_q) ? S_DONE : S_FETCH;
               end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               acc_out_d = acc_q;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         timer_q   <= '0;
         acc_q     <= '0;
         acc_out_q <= '0;
         fma_a_q   <= '0;
         fma_b_q   <= '0;
         fma_c_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         acc_q     <= acc_d;
         acc_out_q <= acc_out_d;
         fma_a_q   <= fma_a_d;
         fma_b_q   <= fma_b_d;
         fma_c_q   <= fma_c_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer.
// Behavioural FMA model with fixed latency drives the result port.
module tb_fma_dot_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  len = '0;
   logic [31:0] init_c = '0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        fma_req;
   logic [15:0] fma_a;
   logic [15:0] fma_b;
   logic [31:0] fma_c;
   logic        fma_res_valid = 1'b0;
   logic [31:0] fma_res = '0;
   logic        busy;
   logic        done;
   logic [31:0] acc_out;
   logic        err;

   int n_chk = 0;
   int n_fail = 0;

   fma_dot_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .len(len), .init_c(init_c),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b),
      .fma_req(fma_req), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
      .fma_res_valid(fma_res_valid), .fma_res(fma_res),
      .busy(busy), .done(done), .acc_out(acc_out), .err(err)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // FMA model: result appears `fma_lat` negedges after the request.
   int          fma_lat = 3;
   bit          fma_en = 1'b1;
   int          fcnt = 0;
   logic [31:0] fres = '0;
   always @(negedge clk) begin
      fma_res_valid = 1'b0;
      if (fma_req) begin
         fcnt = fma_lat;
         fres = r2f(f2r({fma_a, 16'h0}) * f2r({fma_b, 16'h0}) + f2r(fma_c));
      end else if (fcnt > 0) begin
         fcnt = fcnt - 1;
         if (fcnt == 0 && fma_en) begin
            fma_res_valid = 1'b1;
            fma_res = fres;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]        lenv;
      logic [31:0]       init;
      logic [3:0][15:0]  a;
      logic [3:0][15:0]  b;
      bit                stall;
      bit                fma_on;
      logic [31:0]       exp_acc;
      logic              exp_err;
      int                exp_reqs;
      logic [31:0]       exp_c2;
   } vec_t;

   task automatic run_vec(input vec_t v, output int gap);
      int k = 0, reqs = 0, dn = 0, sc = 0, req_it = -1, done_it = -1;
      logic [31:0] c1 = '0, c2 = '0, acc_res = '0;
      logic err_res = 1'b0;
      bit accf = 1'b0;
      fma_en = v.fma_on;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         if (fma_req) begin
            reqs++;
            if (reqs == 1) c1 = fma_c;
            if (reqs == 2) c2 = fma_c;
            req_it = it;
         end
         if (done) begin
            dn++;
            if (dn == 1) begin
               done_it = it;
               acc_res = acc_out;
               err_res = err;
            end
         end
         if (it == 2 && v.lenv != 0) chk("err_clear_on_start", {31'd0, err}, 0);
         if (accf) k++;
         start  = (it == 0);
         len    = v.lenv;
         init_c = v.init;
         op_valid = (k < int'(v.lenv));
         if (op_valid && v.stall && k == 1 && sc < 5 && op_ready) begin
            op_valid = 1'b0;
            sc++;
            chk("stall_no_req", {31'd0, fma_req}, 0);
         end
         op_a = v.a[(k < 4) ? k : 0];
         op_b = v.b[(k < 4) ? k : 0];
         accf = op_valid && op_ready;
         if (done_it >= 0 && it >= done_it + 3) break;
      end
      start = 1'b0;
      op_valid = 1'b0;
      gap = done_it - req_it;
      if (done_it < 0) chk("done_timeout", 0, 1);
      chk("done_count", dn, 1);
      chk("acc_out", acc_res, v.exp_acc);
      chk("err", {31'd0, err_res}, {31'd0, v.exp_err});
      chk("fma_req_count", reqs, v.exp_reqs);
      if (v.exp_reqs > 0) chk("fma_c_first", c1, v.init);
      if (v.exp_reqs > 1) chk("fma_c_second", c2, v.exp_c2);
      if (v.lenv == 0) chk("len0_done_latency", done_it, 1);
   endtask

   vec_t vecs[6];
   vec_t tv;
   int   gap;
   int   dn;
   int   reqs;
   int   extra;
   logic [31:0] prev;

   initial begin
      vecs[0] = '{8'd2, 32'h3F800000, {16'h0, 16'h0, 16'h4000, 16'h3F80},
                  {16'h0, 16'h0, 16'h4000, 16'h4000}, 1'b0, 1'b1,
                  32'h40E00000, 1'b0, 2, 32'h40400000};
      vecs[1] = vecs[0];
      vecs[1].stall = 1'b1;
      vecs[2] = '{8'd0, 32'h40400000, '0, '0, 1'b0, 1'b1,
                  32'h40400000, 1'b0, 0, 32'h0};
      vecs[3] = '{8'd3, 32'h0, {16'h0, 16'h3F80, 16'h3F80, 16'h3F80},
                  {16'h0, 16'h3F80, 16'h3F80, 16'h3F80}, 1'b0, 1'b1,
                  32'h40400000, 1'b0, 3, 32'h3F800000};
      vecs[4] = '{8'd1, 32'h40000000, {48'h0, 16'hC000},
                  {48'h0, 16'h3F80}, 1'b0, 1'b1,
                  32'h00000000, 1'b0, 1, 32'h0};
      vecs[5] = '{8'd4, 32'h0, {16'h4000, 16'h4000, 16'h4000, 16'h4000},
                  {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 1'b0, 1'b1,
                  32'h41800000, 1'b0, 4, 32'h40800000};

      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {op_ready, fma_req, busy, done, err} | (|acc_out) | (|fma_a) |
          (|fma_b) | (|fma_c), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], gap);
         repeat (3) @(negedge clk);
      end

      // FMA never answers: timeout, then a normal run clears err.
      tv = '{8'd1, 32'h3F800000, {48'h0, 16'h3F80}, {48'h0, 16'h4000},
             1'b0, 1'b0, 32'h3F800000, 1'b1, 1, 32'h0};
      run_vec(tv, gap);
      chk("timeout_gap", gap, 42);
      chk("err_sticky", {31'd0, err}, 1);
      tv.fma_on = 1'b1;
      tv.exp_acc = 32'h40400000;
      tv.exp_err = 1'b0;
      run_vec(tv, gap);
      repeat (3) @(negedge clk);

      // Abort in WAIT; late result must be ignored.
      prev = acc_out;
      start = 1'b1; len = 8'd2; init_c = 32'h0;
      op_valid = 1'b1; op_a = 16'h3F80; op_b = 16'h3F80;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_valid = 1'b0;
      chk("abort_issue_req", {31'd0, fma_req}, 1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_not_busy", {31'd0, busy}, 0);
      dn = 0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) extra++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_stays_idle", extra, 0);
      chk("abort_acc_out", acc_out, prev);
      chk("abort_err", {31'd0, err}, 0);

      // start while busy is ignored.
      start = 1'b1; len = 8'd1; init_c = 32'h40000000;
      op_valid = 1'b1; op_a = 16'h3F80; op_b = 16'h3F80;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_valid = 1'b0;
      reqs = fma_req ? 1 : 0;
      @(negedge clk);
      start = 1'b1; len = 8'd3; init_c = 32'h0;
      @(negedge clk);
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 100; i++) begin
         if (fma_req) reqs++;
         if (done) begin
            dn++;
            break;
         end
         @(negedge clk);
      end
      chk("busy_start_done", dn, 1);
      chk("busy_start_acc", acc_out, 32'h40400000);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy || fma_req) extra++;
      end
      chk("busy_start_reqs", reqs, 1);
      chk("busy_start_no_rerun", extra, 0);

      // Reset pulse in WAIT, then a fresh run.
      start = 1'b1; len = 8'd2; init_c = 32'h3F800000;
      op_valid = 1'b1; op_a = 16'h3F80; op_b = 16'h3F80;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs",
          {op_ready, fma_req, busy, done, err} | (|acc_out) | (|fma_a) |
          (|fma_b) | (|fma_c), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("reset_no_done", dn, 0);
      run_vec(vecs[0], gap);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
